regfile_sb: RTL and testbench

- Parametrised successor to the 32x64 one-hot-select register file.
- Binary-addressed, configurable width and depth, 2 read ports and 1 write port, optional hardwired-zero register.
- Adds write-to-read bypass and a per-register pending-write scoreboard, so the issue stage detects RAW hazards without external tracking.
- Sits between decode/issue (reads, scoreboard set) and writeback (write, scoreboard clear).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 82 ++++++++
 rtl/regfile_sb.sv | 86 ++++++++
 tb/tb_regfile_sb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and read-port bundle for the register file
// and the issue-stage logic that consumes its read ports.
package regfile_pkg;

    localparam int DATA_W_DEF   = 64;
    localparam int NUM_REGS_DEF = 32;

    function automatic int f_addr_w(input int n);
        return $clog2(n);
    endfunction

    localparam int ADDR_W_DEF = f_addr_w(NUM_REGS_DEF);

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
        logic                  busy;
    } rd_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracking: set on issue, clear on writeback,
// busy lookup for both read ports and a sticky error for unexpected writebacks.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = f_addr_w(NUM_REGS),
    parameter bit HAS_ZERO = 1'b1,
    parameter int ZERO_REG = NUM_REGS - 1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_dst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    output logic                busy_a,
    output logic                busy_b,
    output logic                sb_err,
    output logic [NUM_REGS-1:0] pend_vec
);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_next;
    logic                err_hit;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return HAS_ZERO && (int'(a) == ZERO_REG);
    endfunction

    // Issue takes priority: the newly issued producer supersedes the one retiring.
    always_comb begin
        pend_next = pend;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (iss_valid && int'(iss_dst) == int'(r) && !(HAS_ZERO && int'(r) == ZERO_REG)) begin
                pend_next[r] = 1'b1;
            end else if (wr_en && int'(wr_addr) == int'(r)) begin
                pend_next[r] = 1'b0;
            end
        end
    end

    always_comb begin
        err_hit = 1'b0;
        if (wr_en && in_range(wr_addr) && !is_zero(wr_addr)) begin
            err_hit = !pend[wr_addr];
        end
    end

    always_comb begin
        busy_a = 1'b0;
        busy_b = 1'b0;
        if (in_range(rd_addr_a) && !is_zero(rd_addr_a)) begin
            busy_a = pend[rd_addr_a] && !(BYPASS && wr_en && wr_addr == rd_addr_a);
        end
        if (in_range(rd_addr_b) && !is_zero(rd_addr_b)) begin
            busy_b = pend[rd_addr_b] && !(BYPASS && wr_en && wr_addr == rd_addr_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            sb_err <= 1'b0;
        end else begin
            pend <= pend_next;
            if (err_hit) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign pend_vec = pend;

endmodule

// File: rtl/regfile_sb.sv
// Binary-addressed 2R/1W register file with optional hardwired-zero register,
// write-to-read bypass and an attached pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = f_addr_w(NUM_REGS),
    parameter bit HAS_ZERO = 1'b1,
    parameter int ZERO_REG = NUM_REGS - 1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic                busy_a,
    output logic                busy_b,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_dst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                sb_err,
    output logic [NUM_REGS-1:0] pend_vec
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return HAS_ZERO && (int'(a) == ZERO_REG);
    endfunction

    assign wr_ok = wr_en && in_range(wr_addr) && !is_zero(wr_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Zero register and out-of-range addresses win over bypass; wr_ok already excludes both.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (in_range(rd_addr_a) && !is_zero(rd_addr_a)) begin
            rd_data_a = (BYPASS && wr_ok && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
        end
        if (in_range(rd_addr_b) && !is_zero(rd_addr_b)) begin
            rd_data_b = (BYPASS && wr_ok && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .HAS_ZERO (HAS_ZERO),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .sb_err    (sb_err),
        .pend_vec  (pend_vec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x64 bypassing instance plus a
// 6x16 non-bypassing instance for the no-forwarding and out-of-range cases.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [4:0]  rd_addr_a, rd_addr_b, iss_dst, wr_addr;
    logic [63:0] rd_data_a, rd_data_b, wr_data;
    logic        busy_a, busy_b, iss_valid, wr_en, sb_err;
    logic [31:0] pend_vec;

    logic [2:0]  nb_rd_addr_a, nb_rd_addr_b, nb_iss_dst, nb_wr_addr;
    logic [15:0] nb_rd_data_a, nb_rd_data_b, nb_wr_data;
    logic        nb_busy_a, nb_busy_b, nb_iss_valid, nb_wr_en, nb_sb_err;
    logic [5:0]  nb_pend_vec;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b),
        .iss_valid(iss_valid), .iss_dst(iss_dst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_err(sb_err), .pend_vec(pend_vec)
    );

    regfile_sb #(.DATA_W(16), .NUM_REGS(6), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(nb_rd_addr_a), .rd_addr_b(nb_rd_addr_b),
        .rd_data_a(nb_rd_data_a), .rd_data_b(nb_rd_data_b),
        .busy_a(nb_busy_a), .busy_b(nb_busy_b),
        .iss_valid(nb_iss_valid), .iss_dst(nb_iss_dst),
        .wr_en(nb_wr_en), .wr_addr(nb_wr_addr), .wr_data(nb_wr_data),
        .sb_err(nb_sb_err), .pend_vec(nb_pend_vec)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_dst = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic test_reset();
        idle();
        rd_addr_a = '0; rd_addr_b = '0;
        nb_iss_valid = 1'b0; nb_iss_dst = '0; nb_wr_en = 1'b0;
        nb_wr_addr = '0; nb_wr_data = '0; nb_rd_addr_a = '0; nb_rd_addr_b = '0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            n_checks++;
            if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d: data_a=%h data_b=%h busy_a=%b busy_b=%b, required 0", i, rd_data_a, rd_data_b, busy_a, busy_b);
            end
        end
        n_checks++;
        if (pend_vec !== 32'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pend_vec=%h sb_err=%b, required 0/0", pend_vec, sb_err);
        end
    endtask

    task automatic test_issue_wb();
        iss_valid = 1'b1; iss_dst = 5'd5;
        tick();
        idle();
        rd_addr_a = 5'd5;
        #1;
        n_checks++;
        if (pend_vec !== 32'h0000_0020 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_pend: pend_vec=%h busy_a=%b, required 00000020/1", pend_vec, busy_a);
        end
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0000_0001;
        #1;
        n_checks++;
        if (rd_data_a !== 64'hDEAD_BEEF_0000_0001 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_bypass: rd_data_a=%h busy_a=%b, required deadbeef00000001/0", rd_data_a, busy_a);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (pend_vec !== 32'd0 || rd_data_a !== 64'hDEAD_BEEF_0000_0001 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_commit: pend_vec=%h rd_data_a=%h busy_a=%b, required 0/deadbeef00000001/0", pend_vec, rd_data_a, busy_a);
        end
    endtask

    task automatic test_zero_reg();
        iss_valid = 1'b1; iss_dst = 5'd31;
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
        rd_addr_a = 5'd31;
        #1;
        n_checks++;
        if (rd_data_a !== 64'd0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_bypass: rd_data_a=%h busy_a=%b, required 0/0", rd_data_a, busy_a);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (pend_vec !== 32'd0 || rd_data_a !== 64'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: pend_vec=%h rd_data_a=%h sb_err=%b, required 0/0/0", pend_vec, rd_data_a, sb_err);
        end
    endtask

    task automatic test_set_clear();
        iss_valid = 1'b1; iss_dst = 5'd7;
        tick();
        iss_valid = 1'b1; iss_dst = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd42;
        tick();
        idle();
        rd_addr_b = 5'd7;
        #1;
        n_checks++;
        if (pend_vec !== 32'h0000_0080 || rd_data_b !== 64'd42 || busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL set_over_clear: pend_vec=%h rd_data_b=%0d busy_b=%b, required 00000080/42/1", pend_vec, rd_data_b, busy_b);
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd43;
        tick();
        idle();
        // Issue and read the same register in one cycle must not self-block.
        rd_addr_b = 5'd9;
        iss_valid = 1'b1; iss_dst = 5'd9;
        #1;
        n_checks++;
        if (busy_b !== 1'b0 || pend_vec !== 32'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_read_same: busy_b=%b pend_vec=%h sb_err=%b, required 0/0/0", busy_b, pend_vec, sb_err);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_read_next: busy_b=%b, required 1", busy_b);
        end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'd9;
        tick();
        idle();
    endtask

    task automatic test_spurious();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd3;
        tick();
        idle();
        rd_addr_a = 5'd3;
        #1;
        n_checks++;
        if (sb_err !== 1'b1 || rd_data_a !== 64'd3) begin
            n_fail++;
            $display("FAIL spurious_wb: sb_err=%b rd_data_a=%0d, required 1/3", sb_err, rd_data_a);
        end
        iss_valid = 1'b1; iss_dst = 5'd4;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'd4;
        tick();
        idle();
        tick();
        n_checks++;
        if (sb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_err_sticky: sb_err=%b, required 1", sb_err);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_err_reset: sb_err=%b, required 0", sb_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 4; i++) begin
            iss_valid = 1'b1; iss_dst = 5'(i);
            tick();
        end
        idle();
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 64'(100 + i);
            tick();
        end
        idle();
        for (int i = 1; i <= 4; i++) begin
            iss_valid = 1'b1; iss_dst = 5'(i);
            tick();
        end
        idle();
        rd_addr_a = 5'd2; rd_addr_b = 5'd4;
        #1;
        n_checks++;
        if (pend_vec !== 32'h0000_001E || rd_data_a !== 64'd102 || rd_data_b !== 64'd104 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset: pend_vec=%h a=%0d b=%0d sb_err=%b, required 0000001e/102/104/0", pend_vec, rd_data_a, rd_data_b, sb_err);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pend_vec !== 32'd0 || rd_data_a !== 64'd0 || rd_data_b !== 64'd0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: pend_vec=%h a=%h b=%h busy_a=%b, required 0/0/0/0", pend_vec, rd_data_a, rd_data_b, busy_a);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_no_bypass();
        nb_iss_valid = 1'b1; nb_iss_dst = 3'd2;
        tick();
        nb_iss_valid = 1'b0;
        nb_rd_addr_a = 3'd2;
        nb_wr_en = 1'b1; nb_wr_addr = 3'd2; nb_wr_data = 16'hBEEF;
        #1;
        n_checks++;
        if (nb_rd_data_a !== 16'h0000 || nb_busy_a !== 1'b1 || nb_pend_vec !== 6'b000100) begin
            n_fail++;
            $display("FAIL nb_same_cycle: data=%h busy=%b pend=%b, required 0000/1/000100", nb_rd_data_a, nb_busy_a, nb_pend_vec);
        end
        tick();
        nb_wr_en = 1'b0;
        #1;
        n_checks++;
        if (nb_rd_data_a !== 16'hBEEF || nb_busy_a !== 1'b0 || nb_pend_vec !== 6'b0) begin
            n_fail++;
            $display("FAIL nb_next_cycle: data=%h busy=%b pend=%b, required beef/0/000000", nb_rd_data_a, nb_busy_a, nb_pend_vec);
        end
        nb_iss_valid = 1'b1; nb_iss_dst = 3'd6;
        nb_wr_en = 1'b1; nb_wr_addr = 3'd7; nb_wr_data = 16'hFFFF;
        tick();
        nb_iss_valid = 1'b1; nb_iss_dst = 3'd5;
        nb_wr_en = 1'b1; nb_wr_addr = 3'd5; nb_wr_data = 16'h1234;
        tick();
        nb_iss_valid = 1'b0; nb_wr_en = 1'b0;
        nb_rd_addr_a = 3'd7; nb_rd_addr_b = 3'd6;
        #1;
        n_checks++;
        if (nb_pend_vec !== 6'b0 || nb_sb_err !== 1'b0 || nb_rd_data_a !== 16'h0 || nb_rd_data_b !== 16'h0
            || nb_busy_a !== 1'b0 || nb_busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL nb_out_of_range: pend=%b err=%b a=%h b=%h busy=%b%b, required 0/0/0/0/00",
                     nb_pend_vec, nb_sb_err, nb_rd_data_a, nb_rd_data_b, nb_busy_a, nb_busy_b);
        end
        nb_rd_addr_a = 3'd5; nb_rd_addr_b = 3'd2;
        #1;
        n_checks++;
        if (nb_rd_data_a !== 16'h0 || nb_rd_data_b !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL nb_zero_reg: a=%h b=%h, required 0000/beef", nb_rd_data_a, nb_rd_data_b);
        end
    endtask

    initial begin
        test_reset();
        test_issue_wb();
        test_zero_reg();
        test_set_clear();
        test_spurious();
        test_async_reset();
        test_no_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
